// File: rtl/uart_link_pkg.sv
// ---------------------------------------------------------------------------
// uart_link_pkg
// Shared definitions for the UART command-line path: control character
// codes, the printable ASCII window and the line assembler state type.
// ---------------------------------------------------------------------------
package uart_link_pkg;

   localparam logic [7:0] CHAR_CR       = 8'h0D;
   localparam logic [7:0] CHAR_LF       = 8'h0A;
   localparam logic [7:0] CHAR_PRINT_LO = 8'h20;
   localparam logic [7:0] CHAR_PRINT_HI = 8'h7E;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DISCARD = 2'd2
   } line_state_e;

endpackage

// File: rtl/line_idle_timer.sv
// ---------------------------------------------------------------------------
// line_idle_timer
// Counts clocks since the last receiver strobe. 'expired' pulses for one
// cycle on the clock that completes TIMEOUT_CYCLES idle clocks; a kick in
// that same cycle wins and reloads the timer instead.
//
// Ports
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset (timer reloaded)
//   kick     reload request (any rx_valid / rx_error)
//   expired  one-cycle combinational timeout indication
// ---------------------------------------------------------------------------
module line_idle_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic kick,
   output logic expired
);

   localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] IDLE_END = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] IDLE_SAT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] idle_reg;

   // Saturating at TIMEOUT_CYCLES keeps 'expired' a single pulse per idle
   // stretch, no matter how long the line stays quiet afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_reg <= '0;
      end else if (kick) begin
         idle_reg <= '0;
      end else if (idle_reg != IDLE_SAT) begin
         idle_reg <= idle_reg + CW'(1);
      end
   end

   assign expired = !kick && (idle_reg == IDLE_END);

endmodule

// File: rtl/uart_line_assembler.sv
// ---------------------------------------------------------------------------
// uart_line_assembler
// Assembles fixed-length command lines from a UART character stream. A line
// of exactly CHARACTER_COUNT printable characters closed by CR or LF is
// published on sr_data with a one-cycle line_valid pulse; malformed, too
// short, too long, errored or timed-out lines produce a frame_drop pulse.
//
// Ports
//   clk         sole clock, rising edge
//   reset_n     asynchronous active-low reset
//   rx_data     received character
//   rx_valid    one-cycle strobe qualifying rx_data
//   rx_error    one-cycle framing/parity error strobe
//   sr_data     last published line, first character in the MSB slot
//   line_valid  one-cycle pulse: new sr_data
//   frame_drop  one-cycle pulse: line discarded
//   busy        high while a line is being collected or discarded
// ---------------------------------------------------------------------------
module uart_line_assembler
   import uart_link_pkg::*;
#(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned CHARACTER_COUNT = 10,
   parameter int unsigned TIMEOUT_CYCLES  = 1_000_000
) (
   input  logic                                  clk,
   input  logic                                  reset_n,
   input  logic [DATA_WIDTH-1:0]                 rx_data,
   input  logic                                  rx_valid,
   input  logic                                  rx_error,
   output logic [DATA_WIDTH*CHARACTER_COUNT-1:0] sr_data,
   output logic                                  line_valid,
   output logic                                  frame_drop,
   output logic                                  busy
);

   localparam int unsigned LINE_W = DATA_WIDTH * CHARACTER_COUNT;
   localparam int unsigned CNT_W  = $clog2(CHARACTER_COUNT + 2);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHARACTER_COUNT);
   localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(CHARACTER_COUNT + 1);

   localparam logic [DATA_WIDTH-1:0] CR_W = DATA_WIDTH'(CHAR_CR);
   localparam logic [DATA_WIDTH-1:0] LF_W = DATA_WIDTH'(CHAR_LF);
   localparam logic [DATA_WIDTH-1:0] LO_W = DATA_WIDTH'(CHAR_PRINT_LO);
   localparam logic [DATA_WIDTH-1:0] HI_W = DATA_WIDTH'(CHAR_PRINT_HI);

   line_state_e       state_reg,      state_next;
   logic [CNT_W-1:0]  count_reg,      count_next;
   logic [LINE_W-1:0] work_reg,       work_next;
   logic [LINE_W-1:0] sr_data_reg,    sr_data_next;
   logic              line_valid_reg, line_valid_next;
   logic              frame_drop_reg, frame_drop_next;

   logic              is_term;
   logic              is_print;
   logic              kick;
   logic              timeout;
   logic [LINE_W-1:0] work_shifted;

   assign is_term      = (rx_data == CR_W) || (rx_data == LF_W);
   assign is_print     = (rx_data >= LO_W) && (rx_data <= HI_W);
   assign kick         = rx_valid || rx_error;
   // Newest character enters the LSB slot; the oldest falls off the top.
   assign work_shifted = (work_reg << DATA_WIDTH) | LINE_W'(rx_data);

   line_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .kick    (kick),
      .expired (timeout)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_IDLE;
         count_reg      <= '0;
         work_reg       <= '0;
         sr_data_reg    <= '0;
         line_valid_reg <= 1'b0;
         frame_drop_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         count_reg      <= count_next;
         work_reg       <= work_next;
         sr_data_reg    <= sr_data_next;
         line_valid_reg <= line_valid_next;
         frame_drop_reg <= frame_drop_next;
      end
   end

   // Next-state logic. rx_error always takes priority over rx_valid, and
   // 'timeout' can only be high in a cycle with no strobe at all.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (rx_error) begin
               state_next = ST_DISCARD;
            end else if (rx_valid && is_print) begin
               state_next = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            if (rx_error) begin
               state_next = ST_DISCARD;
            end else if (rx_valid) begin
               if (is_term) begin
                  state_next = ST_IDLE;
               end else if (!is_print || (count_reg == CNT_FULL)) begin
                  // Control character, or this character overflows the line
                  state_next = ST_DISCARD;
               end
            end else if (timeout) begin
               state_next = ST_IDLE;
            end
         end
         ST_DISCARD: begin
            if (!rx_error && ((rx_valid && is_term) || timeout)) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Datapath and pulse outputs (registered one cycle later)
   always_comb begin
      count_next      = count_reg;
      work_next       = work_reg;
      sr_data_next    = sr_data_reg;
      line_valid_next = 1'b0;
      frame_drop_next = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            // Terminators and stray control characters here are ignored
            if (!rx_error && rx_valid && is_print) begin
               work_next  = work_shifted;
               count_next = CNT_W'(1);
            end
         end
         ST_COLLECT: begin
            if (rx_error) begin
               count_next = count_reg;
            end else if (rx_valid) begin
               if (is_term) begin
                  count_next = '0;
                  if (count_reg == CNT_FULL) begin
                     sr_data_next    = work_reg;
                     line_valid_next = 1'b1;
                  end else begin
                     frame_drop_next = 1'b1;
                  end
               end else if (is_print) begin
                  work_next = work_shifted;
                  if (count_reg != CNT_OVER) begin
                     count_next = count_reg + CNT_W'(1);
                  end
               end
            end else if (timeout) begin
               count_next      = '0;
               frame_drop_next = 1'b1;
            end
         end
         ST_DISCARD: begin
            if (!rx_error && ((rx_valid && is_term) || timeout)) begin
               count_next      = '0;
               frame_drop_next = 1'b1;
            end
         end
         default: begin
            count_next = '0;
         end
      endcase
   end

   assign sr_data    = sr_data_reg;
   assign line_valid = line_valid_reg;
   assign frame_drop = frame_drop_reg;
   assign busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_line_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_line_assembler
// Table of command lines with expected publish/drop counts, hand-written
// timeout / reset / error sequences, and a randomized phase. Every cycle is
// also compared against a queue-based reference model of the line rules.
// ---------------------------------------------------------------------------
module tb_uart_line_assembler;

   localparam int DW = 8;
   localparam int CC = 10;
   localparam int TO = 16;
   localparam int LW = DW * CC;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_valid = 1'b0;
   logic          rx_error = 1'b0;
   logic [LW-1:0] sr_data;
   logic          line_valid;
   logic          frame_drop;
   logic          busy;

   always #5 clk = ~clk;

   uart_line_assembler #(
      .DATA_WIDTH      (DW),
      .CHARACTER_COUNT (CC),
      .TIMEOUT_CYCLES  (TO)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_error   (rx_error),
      .sr_data    (sr_data),
      .line_valid (line_valid),
      .frame_drop (frame_drop),
      .busy       (busy)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int ev_lines, ev_drops;

   // Reference model: the current line is a queue of characters, plus a
   // "discarding" flag and the number of clocks since the last strobe.
   byte unsigned  m_q[$];
   bit            m_disc;
   int            m_idle;
   logic [LW-1:0] m_sr;
   bit            m_lv, m_fd;

   function automatic bit f_term(byte unsigned c);
      return (c == 8'h0D) || (c == 8'h0A);
   endfunction

   function automatic bit f_print(byte unsigned c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

   function automatic logic [LW-1:0] pack_str(string s);
      logic [LW-1:0] r = '0;
      for (int i = 0; i < s.len(); i++) r = (r << DW) | LW'(s[i]);
      return r;
   endfunction

   function automatic logic [LW-1:0] pack_q();
      logic [LW-1:0] r = '0;
      foreach (m_q[i]) r = (r << DW) | LW'(m_q[i]);
      return r;
   endfunction

   // Value of the four hex digits at the tail of a line ("... 0xHHHH")
   function automatic int hex_tail(logic [LW-1:0] s);
      int          v = 0;
      byte unsigned c;
      for (int k = 3; k >= 0; k--) begin
         c = s[k*DW +: DW];
         if (c >= 8'h30 && c <= 8'h39)      v = v * 16 + (c - 8'h30);
         else if (c >= 8'h41 && c <= 8'h46) v = v * 16 + (c - 8'h41 + 10);
         else                               v = v * 16;
      end
      return v;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_disc = 1'b0;
      m_idle = 0;
      m_sr   = '0;
      m_lv   = 1'b0;
      m_fd   = 1'b0;
   endtask

   task automatic model_step(input bit v, input bit e, input byte unsigned d);
      m_lv = 1'b0;
      m_fd = 1'b0;
      if (v || e) m_idle = 0;
      else        m_idle++;
      if (e) begin
         m_q.delete();
         m_disc = 1'b1;
      end else if (v) begin
         if (f_term(d)) begin
            if (m_disc) begin
               m_fd = 1'b1;
               m_disc = 1'b0;
            end else if (m_q.size() == CC) begin
               m_lv = 1'b1;
               m_sr = pack_q();
               m_q.delete();
            end else if (m_q.size() > 0) begin
               m_fd = 1'b1;
               m_q.delete();
            end
         end else if (!m_disc) begin
            if (f_print(d)) begin
               m_q.push_back(d);
               if (m_q.size() > CC) begin
                  m_q.delete();
                  m_disc = 1'b1;
               end
            end else if (m_q.size() > 0) begin
               m_q.delete();
               m_disc = 1'b1;
            end
         end
      end else if (m_idle == TO && (m_disc || m_q.size() > 0)) begin
         m_fd = 1'b1;
         m_disc = 1'b0;
         m_q.delete();
      end
   endtask

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive at the falling edge, compare just after the rising edge.
   task automatic cyc(input bit v, input bit e, input byte unsigned d);
      rx_valid = v;
      rx_error = e;
      rx_data  = (v || e) ? d : 8'($urandom);
      @(posedge clk);
      #1;
      model_step(v, e, d);
      check("line_valid", LW'(line_valid), LW'(m_lv));
      check("frame_drop", LW'(frame_drop), LW'(m_fd));
      check("busy", LW'(busy), LW'(m_disc || (m_q.size() > 0)));
      check("sr_data", sr_data, m_sr);
      check("pulse_excl", LW'(line_valid & frame_drop), '0);
      if (line_valid) ev_lines++;
      if (frame_drop) ev_drops++;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         cyc(1'b1, 1'b0, s[i]);
         cyc(1'b0, 1'b0, 8'h00);
      end
   endtask

   typedef struct {
      string        txt;
      int           err_at;   // rx_error strobe before this character index
      int           bad_at;   // 0x01 control character before this index
      byte unsigned t1;       // terminators, 0 = none
      byte unsigned t2;
      int           exp_lines;
      int           exp_drops;
      int           exp_val;  // hex value of published line, -1 = not checked
   } vec_t;

   localparam int NV = 10;
   vec_t vecs[NV];

   logic [LW-1:0] exp_sr;
   int            len, r, g;
   byte unsigned  c;

   initial begin
      #2ms;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{"SW: 0x00A5",     -1, -1, 8'h0D, 8'h00, 1, 0, 16'h00A5};
      vecs[1] = '{"BT: 0x001F",     -1, -1, 8'h0D, 8'h0A, 1, 0, 16'h001F};
      vecs[2] = '{"ABCDEFGHIJK",    -1, -1, 8'h0D, 8'h00, 0, 1, -1};
      vecs[3] = '{"ABCDEFGHI",      -1, -1, 8'h0D, 8'h00, 0, 1, -1};
      vecs[4] = '{"",               -1, -1, 8'h0D, 8'h0A, 0, 0, -1};
      vecs[5] = '{"abcdSW: 0x1234",  4, -1, 8'h0D, 8'h00, 0, 1, -1};
      vecs[6] = '{"SW: 0x1234",     -1, -1, 8'h0D, 8'h00, 1, 0, 16'h1234};
      vecs[7] = '{"12345678Z9",     -1,  5, 8'h0D, 8'h00, 0, 1, -1};
      vecs[8] = '{"~ !zZ09}{|",     -1, -1, 8'h0D, 8'h00, 1, 0, -1};
      vecs[9] = '{"ABCDEFGHIJ",     -1, -1, 8'h0A, 8'h00, 1, 0, -1};

      // ---- reset state ----
      model_reset();
      exp_sr = '0;
      @(negedge clk);
      @(negedge clk);
      check("rst_sr_data", sr_data, '0);
      check("rst_line_valid", LW'(line_valid), '0);
      check("rst_frame_drop", LW'(frame_drop), '0);
      check("rst_busy", LW'(busy), '0);
      reset_n = 1'b1;
      @(negedge clk);

      // ---- table-driven lines ----
      for (int vi = 0; vi < NV; vi++) begin
         ev_lines = 0;
         ev_drops = 0;
         for (int i = 0; i < vecs[vi].txt.len(); i++) begin
            if (i == vecs[vi].err_at) cyc(1'b0, 1'b1, 8'h00);
            if (i == vecs[vi].bad_at) begin
               cyc(1'b1, 1'b0, 8'h01);
               cyc(1'b0, 1'b0, 8'h00);
            end
            cyc(1'b1, 1'b0, vecs[vi].txt[i]);
            cyc(1'b0, 1'b0, 8'h00);
         end
         if (vecs[vi].t1 != 8'h00) cyc(1'b1, 1'b0, vecs[vi].t1);
         if (vecs[vi].t2 != 8'h00) cyc(1'b1, 1'b0, vecs[vi].t2);
         repeat (3) cyc(1'b0, 1'b0, 8'h00);
         if (vecs[vi].exp_lines > 0) exp_sr = pack_str(vecs[vi].txt);
         check("vec_lines", LW'(ev_lines), LW'(vecs[vi].exp_lines));
         check("vec_drops", LW'(ev_drops), LW'(vecs[vi].exp_drops));
         check("vec_sr_data", sr_data, exp_sr);
         if (vecs[vi].exp_val >= 0)
            check("vec_value", LW'(hex_tail(sr_data)), LW'(vecs[vi].exp_val));
         $display("vec %0d \"%s\": lines=%0d drops=%0d sr=%h",
                  vi, vecs[vi].txt, ev_lines, ev_drops, sr_data);
      end
      check("sw_first_char", LW'(sr_data[79:72]), LW'(8'h41));

      // ---- idle timeout: 5 chars then 16 idle clocks ----
      ev_lines = 0;
      ev_drops = 0;
      send_str("");
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'h48 + 8'(i));
      for (int i = 1; i <= TO; i++) begin
         cyc(1'b0, 1'b0, 8'h00);
         if (i == TO - 1) begin
            check("to_busy_before", LW'(busy), LW'(1'b1));
            check("to_drop_before", LW'(frame_drop), '0);
         end
      end
      check("to_drop", LW'(frame_drop), LW'(1'b1));
      check("to_busy_after", LW'(busy), '0);
      send_str("TO: 0x0016");
      cyc(1'b1, 1'b0, 8'h0D);
      check("to_next_line", LW'(line_valid), LW'(1'b1));
      check("to_counts", LW'({ev_lines[7:0], ev_drops[7:0]}), LW'(16'h0101));
      $display("timeout seq: lines=%0d drops=%0d", ev_lines, ev_drops);

      // ---- reset mid-line ----
      ev_lines = 0;
      ev_drops = 0;
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 8'h61 + 8'(i));
      reset_n = 1'b0;
      #2;
      check("mid_rst_sr_data", sr_data, '0);
      check("mid_rst_busy", LW'(busy), '0);
      check("mid_rst_pulses", LW'({line_valid, frame_drop}), '0);
      model_reset();
      exp_sr = '0;
      @(negedge clk);
      reset_n = 1'b1;
      repeat (2) cyc(1'b0, 1'b0, 8'h00);
      send_str("RS: 0x0034");
      cyc(1'b1, 1'b0, 8'h0D);
      check("rst_next_sr", sr_data, pack_str("RS: 0x0034"));
      check("rst_counts", LW'({ev_lines[7:0], ev_drops[7:0]}), LW'(16'h0100));
      $display("reset seq: lines=%0d drops=%0d", ev_lines, ev_drops);

      // ---- error and valid together in IDLE ----
      ev_lines = 0;
      ev_drops = 0;
      cyc(1'b1, 1'b1, 8'h41);
      check("errval_busy", LW'(busy), LW'(1'b1));
      send_str("0123456789");
      cyc(1'b1, 1'b0, 8'h0D);
      check("errval_counts", LW'({ev_lines[7:0], ev_drops[7:0]}), LW'(16'h0001));
      $display("error+valid seq: lines=%0d drops=%0d", ev_lines, ev_drops);

      // ---- randomized lines ----
      for (int ln = 0; ln < 300; ln++) begin
         ev_lines = 0;
         ev_drops = 0;
         len = ($urandom_range(0, 3) != 0) ? CC : int'($urandom_range(0, CC + 3));
         for (int i = 0; i < len; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2)      cyc(1'b0, 1'b1, 8'h00);
            else if (r < 3) cyc(1'b1, 1'b1, 8'($urandom_range(32, 126)));
            if (r >= 3 && r < 5) c = 8'($urandom_range(0, 31));
            else if (r == 5)     c = 8'($urandom_range(127, 255));
            else                 c = 8'($urandom_range(32, 126));
            cyc(1'b1, 1'b0, c);
            g = ($urandom_range(0, 39) == 0) ? int'($urandom_range(14, 18))
                                             : int'($urandom_range(0, 2));
            repeat (g) cyc(1'b0, 1'b0, 8'h00);
         end
         cyc(1'b1, 1'b0, ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A);
         if ($urandom_range(0, 2) == 0) cyc(1'b1, 1'b0, 8'h0A);
         repeat ($urandom_range(0, 2)) cyc(1'b0, 1'b0, 8'h00);
         $display("rand %0d: len=%0d lines=%0d drops=%0d", ln, len, ev_lines, ev_drops);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
